// File: rtl/distance_monitor.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// distance_monitor
//
// Turns per-sensor ultrasonic distance samples (cm) into debounced, hysteretic
// stop flags. Each channel also has a fail-safe watchdog. The block also reports
// the nearest live obstacle. Downstream drive logic halts on any_stop.
//
// Ports:
//   clk              system clock, all logic on the rising edge
//   reset            synchronous, active-high reset
//   distance         N packed W-bit samples, channel i at [i*W +: W]
//   distance_valid   per-channel one-cycle sample strobe
//   stop_flag        per-channel stop (state == STOP or timed out), registered
//   any_stop         OR of stop_flag, registered
//   timeout_flag     per-channel watchdog expired, registered
//   nearest_distance minimum latched distance over channels not timed out
//   nearest_channel  index of that channel (lowest index wins ties)
// -----------------------------------------------------------------------------
module distance_monitor #(
    parameter int N              = 2,
    parameter int W              = 12,
    parameter int STOP_CM        = 20,
    parameter int CLEAR_CM       = 25,
    parameter int CONFIRM        = 3,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    localparam int CH_W          = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*W-1:0]     distance,
    input  logic [N-1:0]       distance_valid,
    output logic [N-1:0]       stop_flag,
    output logic               any_stop,
    output logic [N-1:0]       timeout_flag,
    output logic [W-1:0]       nearest_distance,
    output logic [CH_W-1:0]    nearest_channel
);

    // Thresholds are compared as unsigned W-bit values.
    localparam logic [W-1:0] STOP_T  = W'(STOP_CM);
    localparam logic [W-1:0] CLEAR_T = W'(CLEAR_CM);

    // The confirm counter never holds CONFIRM between samples: the sample that
    // would make it reach CONFIRM switches the state and clears it instead.
    // So it only needs to represent 0..CONFIRM-1.
    localparam int               CNT_W    = (CONFIRM > 1) ? $clog2(CONFIRM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONFIRM - 1);

    localparam int              WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    localparam bit              WD_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_STOP  = 1'b1
    } state_t;

    logic [N-1:0] stop_d;
    logic [N-1:0] stop_q;
    logic [N-1:0] to_q;
    logic [W-1:0] last_q [N];

    // ------------------------------------------------------------------
    // Per-channel debounce FSM, watchdog and sample latch
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        logic [W-1:0]     d;
        logic             qualify;
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [WD_W-1:0]  wd_q, wd_d;
        logic             to_ch_q, to_ch_d;
        logic             stop_ch_q, stop_ch_d;
        logic [W-1:0]     last_dist_q, last_dist_d;

        assign d = distance[gi*W +: W];

        // A sample "qualifies" when it pushes toward the opposite state.
        // In STOP, the hysteresis band (STOP_CM, CLEAR_CM) does not qualify.
        assign qualify = (state_q == ST_CLEAR) ? (d <= STOP_T) : (d >= CLEAR_T);

        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            wd_d        = wd_q;
            to_ch_d     = to_ch_q;
            last_dist_d = last_dist_q;
            if (distance_valid[gi]) begin
                // A fresh sample clears the timeout and is processed normally.
                // After a timeout the FSM sits in STOP with cnt=0, so this sample
                // counts as the first release sample.
                wd_d        = '0;
                to_ch_d     = 1'b0;
                last_dist_d = d;
                if (!qualify) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = (state_q == ST_CLEAR) ? ST_STOP : ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (WD_EN && (wd_q != WD_MAX)) begin
                wd_d = wd_q + 1'b1;
                if (wd_d == WD_MAX) begin
                    to_ch_d = 1'b1;
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end
            end
        end

        assign stop_ch_d = (state_d == ST_STOP) | to_ch_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q     <= ST_STOP;
                cnt_q       <= '0;
                wd_q        <= '0;
                to_ch_q     <= 1'b0;
                stop_ch_q   <= 1'b1;
                last_dist_q <= '1;
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                wd_q        <= wd_d;
                to_ch_q     <= to_ch_d;
                stop_ch_q   <= stop_ch_d;
                last_dist_q <= last_dist_d;
            end
        end

        assign stop_d[gi] = stop_ch_d;
        assign stop_q[gi] = stop_ch_q;
        assign to_q[gi]   = to_ch_q;
        assign last_q[gi] = last_dist_q;
    end

    // ------------------------------------------------------------------
    // Nearest live obstacle: minimum over latched samples of channels that
    // are not timed out. It works from the registered latch values, so the
    // result lands two edges after the strobe.
    // ------------------------------------------------------------------
    logic [W-1:0]    min_dist;
    logic [CH_W-1:0] min_ch;
    logic            min_found;

    always_comb begin
        min_dist  = '1;
        min_ch    = '0;
        min_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            // Strict less-than keeps the lowest index on ties. min_found lets
            // a live channel holding all-ones still report its own index.
            if (!to_q[i] && (!min_found || (last_q[i] < min_dist))) begin
                min_found = 1'b1;
                min_dist  = last_q[i];
                min_ch    = CH_W'(i);
            end
        end
    end

    logic            any_stop_q;
    logic [W-1:0]    near_dist_q;
    logic [CH_W-1:0] near_ch_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            any_stop_q  <= 1'b1;
            near_dist_q <= '1;
            near_ch_q   <= '0;
        end else begin
            any_stop_q  <= |stop_d;
            near_dist_q <= min_dist;
            near_ch_q   <= min_ch;
        end
    end

    assign stop_flag        = stop_q;
    assign any_stop         = any_stop_q;
    assign timeout_flag     = to_q;
    assign nearest_distance = near_dist_q;
    assign nearest_channel  = near_ch_q;

endmodule

// File: tb/tb_distance_monitor.sv
`timescale 1ns/1ps
// Testbench for distance_monitor. It uses directed stimulus. A behavioural
// model checks every cycle, and literal expectations pin key moments.
module tb_distance_monitor;

    localparam int N        = 2;
    localparam int W        = 12;
    localparam int STOP_CM  = 20;
    localparam int CLEAR_CM = 25;
    localparam int CONFIRM  = 3;
    localparam int TMO      = 20;
    localparam int CH_W     = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*W-1:0]  distance;
    logic [N-1:0]    distance_valid;
    logic [N-1:0]    stop_flag;
    logic            any_stop;
    logic [N-1:0]    timeout_flag;
    logic [W-1:0]    nearest_distance;
    logic [CH_W-1:0] nearest_channel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    distance_monitor #(
        .N(N), .W(W), .STOP_CM(STOP_CM), .CLEAR_CM(CLEAR_CM),
        .CONFIRM(CONFIRM), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .distance         (distance),
        .distance_valid   (distance_valid),
        .stop_flag        (stop_flag),
        .any_stop         (any_stop),
        .timeout_flag     (timeout_flag),
        .nearest_distance (nearest_distance),
        .nearest_channel  (nearest_channel)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: per channel it tracks whether it is stopped, the
    // length of the current run of qualifying samples, idle cycles since the
    // last sample, timeout and last distance. Nearest is computed from the
    // pre-edge state, which gives the extra pipeline cycle.
    // ------------------------------------------------------------------
    bit m_stop [N];
    int m_run  [N];
    int m_idle [N];
    bit m_tmo  [N];
    int m_last [N];
    int m_near_d;
    int m_near_ch;
    bit m_live = 1'b0;

    task automatic model_step();
        int  bd;
        int  bc;
        bit  found;
        int  s;
        bit  qual;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_stop[i] = 1'b1;
                m_run[i]  = 0;
                m_idle[i] = 0;
                m_tmo[i]  = 1'b0;
                m_last[i] = 4095;
            end
            m_near_d  = 4095;
            m_near_ch = 0;
            m_live    = 1'b1;
        end else if (m_live) begin
            bd = 4095; bc = 0; found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!m_tmo[i] && (!found || m_last[i] < bd)) begin
                    found = 1'b1;
                    bd    = m_last[i];
                    bc    = i;
                end
            end
            m_near_d  = bd;
            m_near_ch = bc;
            for (int i = 0; i < N; i++) begin
                if (distance_valid[i]) begin
                    s         = int'(distance[i*W +: W]);
                    m_idle[i] = 0;
                    m_tmo[i]  = 1'b0;
                    m_last[i] = s;
                    qual      = m_stop[i] ? (s >= CLEAR_CM) : (s <= STOP_CM);
                    m_run[i]  = qual ? m_run[i] + 1 : 0;
                    if (m_run[i] == CONFIRM) begin
                        m_stop[i] = !m_stop[i];
                        m_run[i]  = 0;
                    end
                end else if (m_idle[i] < TMO) begin
                    m_idle[i] = m_idle[i] + 1;
                    if (m_idle[i] == TMO) begin
                        m_tmo[i]  = 1'b1;
                        m_stop[i] = 1'b1;
                        m_run[i]  = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_cycle();
        logic [N-1:0] es;
        logic [N-1:0] et;
        for (int i = 0; i < N; i++) begin
            es[i] = m_stop[i] | m_tmo[i];
            et[i] = m_tmo[i];
        end
        check("cyc_stop_flag",    32'(stop_flag),        32'(es));
        check("cyc_any_stop",     32'(any_stop),         32'(|es));
        check("cyc_timeout_flag", 32'(timeout_flag),     32'(et));
        check("cyc_nearest_dist", 32'(nearest_distance), 32'(m_near_d));
        check("cyc_nearest_ch",   32'(nearest_channel),  32'(m_near_ch));
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) if (m_live) compare_cycle();

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 ns after the rising edge.
    // ------------------------------------------------------------------
    task automatic step(input logic [N-1:0] v, input int d0, input int d1);
        distance_valid = v;
        distance[0 +: W] = d0[W-1:0];
        distance[W +: W] = d1[W-1:0];
        @(posedge clk);
        #1;
        distance_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at t=%0t, expected finish earlier", $time);
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        distance_valid = '0;
        distance       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_stop_flag", 32'(stop_flag), 32'd3);
        check("rst_any_stop", 32'(any_stop), 32'd1);
        check("rst_timeout", 32'(timeout_flag), 32'd0);
        check("rst_nearest_dist", 32'(nearest_distance), 32'd4095);
        check("rst_nearest_ch", 32'(nearest_channel), 32'd0);

        // 1: three release samples on ch0; ch1 stays in the band
        step(2'b11, 30, 22);
        check("s1_after1_stop", 32'(stop_flag), 32'd3);
        step(2'b11, 30, 22);
        step(2'b11, 30, 22);
        check("s1_after3_stop", 32'(stop_flag), 32'd2);
        check("s1_any_stop", 32'(any_stop), 32'd1);

        // 2: the stop run is broken by 21; exactly 20 qualifies
        step(2'b11, 20, 22);
        step(2'b11, 20, 22);
        step(2'b11, 21, 22);
        step(2'b11, 20, 22);
        step(2'b11, 20, 22);
        check("s2_after5_stop", 32'(stop_flag), 32'd2);
        step(2'b11, 20, 22);
        check("s2_after6_stop", 32'(stop_flag), 32'd3);

        // 3: hysteresis band holds STOP; then 25 x3 releases ch0, 30 x3 releases ch1
        step(2'b11, 22, 22);
        step(2'b11, 24, 22);
        step(2'b11, 23, 22);
        check("s3_band_stop", 32'(stop_flag), 32'd3);
        step(2'b11, 25, 30);
        step(2'b11, 25, 30);
        check("s3_after2_stop", 32'(stop_flag), 32'd3);
        step(2'b11, 25, 30);
        check("s3_release_stop", 32'(stop_flag), 32'd0);
        check("s3_release_any", 32'(any_stop), 32'd0);

        // 4: ch1 watchdog
        repeat (19) step(2'b01, 30, 0);
        check("s4_19_timeout", 32'(timeout_flag), 32'd0);
        check("s4_19_stop", 32'(stop_flag), 32'd0);
        step(2'b01, 30, 0);
        check("s4_20_timeout", 32'(timeout_flag), 32'd2);
        check("s4_20_stop", 32'(stop_flag), 32'd2);
        check("s4_20_any", 32'(any_stop), 32'd1);
        step(2'b11, 30, 40);
        check("s4_wake_timeout", 32'(timeout_flag), 32'd0);
        check("s4_wake_stop", 32'(stop_flag), 32'd2);
        step(2'b11, 30, 40);
        check("s4_wake2_stop", 32'(stop_flag), 32'd2);
        step(2'b11, 30, 40);
        check("s4_wake3_stop", 32'(stop_flag), 32'd0);

        // 5: nearest tracking, two-cycle latency
        step(2'b11, 50, 30);
        check("s5_lat1_dist", 32'(nearest_distance), 32'd30);
        check("s5_lat1_ch", 32'(nearest_channel), 32'd0);
        idle(1);
        check("s5_dist", 32'(nearest_distance), 32'd30);
        check("s5_ch", 32'(nearest_channel), 32'd1);
        step(2'b11, 30, 30);
        idle(1);
        check("s5_tie_ch", 32'(nearest_channel), 32'd0);
        repeat (20) step(2'b01, 50, 0);
        check("s5_ch1to_timeout", 32'(timeout_flag), 32'd2);
        check("s5_ch1to_dist", 32'(nearest_distance), 32'd50);
        check("s5_ch1to_ch", 32'(nearest_channel), 32'd0);
        idle(25);
        check("s5_allto_timeout", 32'(timeout_flag), 32'd3);
        check("s5_allto_dist", 32'(nearest_distance), 32'd4095);
        check("s5_allto_ch", 32'(nearest_channel), 32'd0);
        check("s5_allto_stop", 32'(stop_flag), 32'd3);

        // 6: extremes
        step(2'b11, 4095, 4095);
        check("s6_wake_timeout", 32'(timeout_flag), 32'd0);
        check("s6_wake_stop", 32'(stop_flag), 32'd3);
        step(2'b11, 4095, 4095);
        step(2'b11, 4095, 4095);
        check("s6_max_release", 32'(stop_flag), 32'd0);
        step(2'b10, 0, 0);
        step(2'b10, 0, 0);
        step(2'b10, 0, 0);
        check("s6_zero_stop", 32'(stop_flag), 32'd2);
        idle(1);
        check("s6_zero_dist", 32'(nearest_distance), 32'd0);
        check("s6_zero_ch", 32'(nearest_channel), 32'd1);
        repeat (22) step(2'b10, 0, 4095);
        check("s6_max_near_dist", 32'(nearest_distance), 32'd4095);
        check("s6_max_near_ch", 32'(nearest_channel), 32'd1);
        check("s6_max_stop", 32'(stop_flag), 32'd1);

        // 7: mid-sequence reset discards a partial release count on ch0
        step(2'b01, 30, 0);
        step(2'b01, 30, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("s7_rst_stop", 32'(stop_flag), 32'd3);
        check("s7_rst_timeout", 32'(timeout_flag), 32'd0);
        check("s7_rst_dist", 32'(nearest_distance), 32'd4095);
        step(2'b01, 30, 0);
        step(2'b01, 30, 0);
        check("s7_cnt_discarded", 32'(stop_flag), 32'd3);
        step(2'b01, 30, 0);
        check("s7_release", 32'(stop_flag), 32'd2);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/distance_monitor.md
# distance_monitor

Multi-channel successor to the single-threshold ultrasonic distance check. It turns per-sensor distance samples (cm) into registered, debounced, hysteretic stop flags with a fail-safe watchdog. It also reports the nearest live obstacle. It sits between the ultrasonic echo-measurement blocks and the motor/drive control logic, which halts on `any_stop`.

## Interface
- `N`, 2, number of sensor channels (≥1)
- `W`, 12, distance width in cm
- `STOP_CM`, 20, stop threshold; sample qualifies for stop when distance ≤ STOP_CM
- `CLEAR_CM`, 25, release threshold; sample qualifies for release when distance ≥ CLEAR_CM (CLEAR_CM > STOP_CM required)
- `CONFIRM`, 3, consecutive qualifying samples needed to change state (≥1)
- `TIMEOUT_CYCLES`, 5_000_000, clock cycles without a valid sample before channel timeout (100 ms at 50 MHz); 0 disables the watchdog

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `distance`  in  N*W  packed samples; channel i at [i*W +: W]
- `distance_valid`  in  N  one-cycle strobe per channel; sample is taken only when high
- `stop_flag`  out  N  per-channel stop (registered)
- `any_stop`  out  1  OR of `stop_flag` (registered)
- `timeout_flag`  out  N  channel watchdog expired (registered)
- `nearest_distance`  out  W  minimum latched distance over non-timed-out channels
- `nearest_channel`  out  CH_W  index of that channel; CH_W = max(1, $clog2(N))

Clocking and reset (already decided): one clock; reset is synchronous and active-high.

## Operation
- Each channel has an FSM with states CLEAR and STOP, a confirm counter `cnt` (0..CONFIRM), a watchdog counter, and a latched last distance `last_d`.
- CLEAR state: a valid sample with d ≤ STOP_CM increments `cnt`. When `cnt` reaches CONFIRM, go to STOP and set `cnt`=0. A valid sample with d > STOP_CM sets `cnt`=0.
- STOP state: a valid sample with d ≥ CLEAR_CM increments `cnt`. When `cnt` reaches CONFIRM, go to CLEAR and set `cnt`=0. A valid sample with d < CLEAR_CM (hysteresis band included) sets `cnt`=0.
- Cycles without `distance_valid` leave `cnt` and state unchanged.
- Watchdog: cleared to 0 on every valid sample. Otherwise it increments each cycle and saturates at TIMEOUT_CYCLES. On reaching TIMEOUT_CYCLES, `timeout_flag`=1, the FSM is forced to STOP, and `cnt`=0.
- `timeout_flag` clears on the edge that takes the next valid sample. That sample is processed normally, counting as release sample #1.
- `stop_flag[i]` = (state == STOP) | timeout. `any_stop` = |stop_flag.
- On each valid sample, `last_d` ← d.
- Nearest: minimum `last_d` over channels with timeout=0. Ties go to the lowest index. If every channel is timed out: `nearest_distance` = all-ones, `nearest_channel` = 0.
- Arithmetic: unsigned W-bit compares. Thresholds are truncated to W bits at elaboration.

## Timing
- Reset values:
  - state = STOP (fail-safe)
  - `stop_flag` = all 1, `any_stop` = 1
  - `timeout_flag` = 0, cnt = 0, watchdog = 0
  - `last_d` = all-ones
  - `nearest_distance` = all-ones, `nearest_channel` = 0
- Reset asserted mid-sequence discards `cnt` and returns to the above on the next edge.
- Stop/release latency: the edge that accepts the CONFIRM-th qualifying sample updates the state. `stop_flag` and `any_stop` are visible the following cycle.
- Timeout latency: `timeout_flag` and forced `stop_flag` rise on the edge where the watchdog reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES edges after the last valid sample.
- Nearest outputs: 2-cycle latency from the valid strobe (latch, then registered min tree).
- Back-to-back valid strobes on consecutive cycles are all accepted. Channels are fully independent.
- CONFIRM=1: single-sample switching.

## Test plan
Parameters for all scenarios: N=2, W=12, STOP_CM=20, CLEAR_CM=25, CONFIRM=3, TIMEOUT_CYCLES=20.

1. Reset, then three valid samples of 30 on ch0 -> `stop_flag[0]` stays 1 until the cycle after the 3rd sample, then 0. `any_stop` stays 1 (ch1 still in STOP).
2. ch0 in CLEAR: samples 20,20,21,20,20,20 -> `cnt` resets at 21. `stop_flag[0]` rises only after the 6th sample. Also checks that exactly 20 qualifies for stop.
3. Hysteresis: ch0 in STOP, samples 22,24,23 (all in band) -> no release. Then 25,25,25 -> release after the 3rd.
4. Watchdog: ch1 in CLEAR, no valid for 20 cycles -> `timeout_flag[1]`=1 and `stop_flag[1]`=1 on the 20th edge. Then one sample of 40 -> `timeout_flag[1]`=0, `stop_flag[1]` still 1. Two more samples of 40 -> `stop_flag[1]`=0.
5. Nearest: ch0=50, ch1=30 -> `nearest_distance`=30, `nearest_channel`=1 two cycles after the strobe. Tie at 30/30 -> channel 0. ch1 times out -> nearest=50, ch0. Both timed out -> 4095, 0.
6. Extremes: samples 0 and 4095 -> 0 counts as a stop sample. 4095 counts as a release sample and is a valid nearest value.
